switch_driver: RTL and testbench

//   Control-side counterpart of the edge-gated switch: turns a raw push-button into

---
 rtl/switch_pkg.sv | 33 +++
 rtl/key_debounce.sv | 78 +++++++
 rtl/switch_driver.sv | 171 +++++++++++++++++
 tb/tb_switch_driver.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
//   Shared definitions for the switch driver: the controller state encoding
//   and a helper that sizes counters so they can hold their full terminal
//   count without truncation.
//   No ports (package).
// ---------------------------------------------------------------------------
package switch_pkg;

    // Fixed 3-bit encodings so the state register is stable across tools
    localparam logic [2:0] ENC_INIT      = 3'd0;
    localparam logic [2:0] ENC_IDLE_OFF  = 3'd1;
    localparam logic [2:0] ENC_PULSE_ON  = 3'd2;
    localparam logic [2:0] ENC_HOLD_ON   = 3'd3;
    localparam logic [2:0] ENC_PULSE_OFF = 3'd4;

    typedef enum logic [2:0] {
        S_INIT      = ENC_INIT,
        S_IDLE_OFF  = ENC_IDLE_OFF,
        S_PULSE_ON  = ENC_PULSE_ON,
        S_HOLD_ON   = ENC_HOLD_ON,
        S_PULSE_OFF = ENC_PULSE_OFF
    } state_t;

    // Width needed to represent 0..n inclusive; never narrower than one bit
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Brings a raw, bouncing push-button into the clock domain, accepts a new
//   level only after DEBOUNCE_CYCLES consecutive equal synchronised samples,
//   and produces a one-cycle strobe on each accepted rising edge.
// Ports
//   i_clk    in   system clock
//   i_rst_n  in   asynchronous active-low reset
//   i_raw    in   raw key, asynchronous to i_clk
//   o_level  out  debounced key level
//   o_rise   out  one-cycle strobe on a debounced 0->1 change
// ---------------------------------------------------------------------------
module key_debounce
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_levelDly;
    logic            r_rise;
    logic [DB_W-1:0] r_stableCnt;

    // Two-flop synchroniser for the asynchronous key input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // sample matching the current level restarts the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level     <= 1'b0;
            r_stableCnt <= '0;
        end else if (r_sync2 != r_level) begin
            if (r_stableCnt == DB_LAST) begin
                r_level     <= r_sync2;
                r_stableCnt <= '0;
            end else begin
                r_stableCnt <= r_stableCnt + 1'b1;
            end
        end else begin
            r_stableCnt <= '0;
        end
    end

    // Registered edge detect; the extra stage fixes the press-to-pulse latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_levelDly <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_levelDly <= r_level;
            r_rise     <= r_level & ~r_levelDly;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/switch_driver.sv
// ---------------------------------------------------------------------------
// switch_driver
//   Turns a push-button into clean, mutually exclusive ON/OFF command pulses
//   for an edge-gated switch. A press toggles on/off, the switch is turned
//   off automatically after TIMEOUT_CYCLES in the on state (0 disables the
//   timeout), and i_force_off requests an off command.
// Ports
//   i_clk        in   system clock
//   i_rst_n      in   asynchronous active-low reset
//   i_key        in   raw push-button, active high, may bounce
//   i_force_off  in   synchronous level request to switch off
//   o_on         out  registered pulse to the switch ON input
//   o_off        out  registered pulse to the switch OFF input
//   o_state      out  high while the switch is commanded on
// ---------------------------------------------------------------------------
module switch_driver
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int PULSE_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    input  logic i_force_off,
    output logic o_on,
    output logic o_off,
    output logic o_state
);

    localparam int              PW_W    = cnt_width(PULSE_WIDTH);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_WIDTH - 1);

    state_t          r_state;
    logic [PW_W-1:0] r_pulseCnt;
    logic            r_killPend;
    logic            r_gap;
    logic            r_on;
    logic            r_off;
    logic            r_hold;

    logic w_press;
    logic w_keyLevel;
    logic w_unusedKeyLevel;
    logic w_timeout;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_keyDebounce (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_raw  (i_key),
        .o_level(w_keyLevel),
        .o_rise (w_press)
    );

    // Only press events matter here; releases are deliberately ignored
    assign w_unusedKeyLevel = w_keyLevel;

    // Timeout counter: held at zero outside HOLD_ON so every entry starts
    // fresh, and stops at its terminal count instead of wrapping.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int              TO_W    = cnt_width(TIMEOUT_CYCLES);
            localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

            logic [TO_W-1:0] r_toCnt;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_toCnt <= '0;
                end else if (r_state != S_HOLD_ON) begin
                    r_toCnt <= '0;
                end else if (r_toCnt != TO_LAST) begin
                    r_toCnt <= r_toCnt + 1'b1;
                end
            end

            assign w_timeout = (r_state == S_HOLD_ON) && (r_toCnt == TO_LAST);
        end else begin : g_noTimeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Controller FSM. Outputs are registered from the next state. An ON
    // pulse that ends with a pending kill goes to PULSE_OFF through one
    // quiet gap cycle (r_gap) so ON and OFF are never adjacent.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_INIT;
            r_pulseCnt <= '0;
            r_killPend <= 1'b0;
            r_gap      <= 1'b0;
            r_on       <= 1'b0;
            r_off      <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_state    <= S_PULSE_OFF;
                    r_pulseCnt <= '0;
                    r_gap      <= 1'b0;
                    r_off      <= 1'b1;
                end
                S_IDLE_OFF: begin
                    if (w_press) begin
                        r_state    <= S_PULSE_ON;
                        r_pulseCnt <= '0;
                        r_killPend <= 1'b0;
                        r_on       <= 1'b1;
                    end
                end
                S_PULSE_ON: begin
                    if (r_pulseCnt == PW_LAST) begin
                        r_on       <= 1'b0;
                        r_pulseCnt <= '0;
                        r_killPend <= 1'b0;
                        if (r_killPend || i_force_off) begin
                            r_state <= S_PULSE_OFF;
                            r_gap   <= 1'b1;
                        end else begin
                            r_state <= S_HOLD_ON;
                            r_hold  <= 1'b1;
                        end
                    end else begin
                        r_pulseCnt <= r_pulseCnt + 1'b1;
                        if (i_force_off) begin
                            r_killPend <= 1'b1;
                        end
                    end
                end
                S_HOLD_ON: begin
                    if (w_press || i_force_off || w_timeout) begin
                        r_state    <= S_PULSE_OFF;
                        r_pulseCnt <= '0;
                        r_gap      <= 1'b0;
                        r_hold     <= 1'b0;
                        r_off      <= 1'b1;
                    end
                end
                S_PULSE_OFF: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                        r_off <= 1'b1;
                    end else if (r_pulseCnt == PW_LAST) begin
                        r_state    <= S_IDLE_OFF;
                        r_pulseCnt <= '0;
                        r_off      <= 1'b0;
                    end else begin
                        r_pulseCnt <= r_pulseCnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_INIT;
                    r_pulseCnt <= '0;
                    r_killPend <= 1'b0;
                    r_gap      <= 1'b0;
                    r_on       <= 1'b0;
                    r_off      <= 1'b0;
                    r_hold     <= 1'b0;
                end
            endcase
        end
    end

    assign o_on    = r_on;
    assign o_off   = r_off;
    assign o_state = r_hold;

endmodule

// File: tb/tb_switch_driver.sv
// ---------------------------------------------------------------------------
// tb_switch_driver
//   Self-checking bench for switch_driver (DEBOUNCE_CYCLES=4, PULSE_WIDTH=2,
//   TIMEOUT_CYCLES=16) plus a second instance with the timeout disabled.
//   Expected ON/OFF pulses (kind, starting edge, width) are queued when a
//   scenario drives its stimulus; a monitor queues the pulses the DUT
//   actually produced and each scenario drains and compares both queues.
// ---------------------------------------------------------------------------
module tb_switch_driver;

    localparam int DB = 4;

    typedef struct packed {
        logic        isOn;
        logic [31:0] start;
        logic [31:0] width;
    } pulse_t;

    logic clk;
    logic rstN;
    logic key;
    logic forceOff;
    logic onOut;
    logic offOut;
    logic stateOut;
    logic key2;
    logic force2;
    logic on2;
    logic off2;
    logic state2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int overlapCount = 0;
    int gapViolations = 0;

    pulse_t expQ[$];
    pulse_t obsQ[$];

    switch_driver #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_WIDTH    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_key      (key),
        .i_force_off(forceOff),
        .o_on       (onOut),
        .o_off      (offOut),
        .o_state    (stateOut)
    );

    switch_driver #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_WIDTH    (2),
        .TIMEOUT_CYCLES (0)
    ) dutNoTimeout (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_key      (key2),
        .i_force_off(force2),
        .o_on       (on2),
        .o_off      (off2),
        .o_state    (state2)
    );

    // Clock and edge counter; cyc names the posedge that just happened
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pulse monitor on the main DUT, sampling on the falling edge
    logic prevOn = 1'b0;
    logic prevOff = 1'b0;
    int onStart = 0;
    int onLen = 0;
    int offStart = 0;
    int offLen = 0;
    always @(negedge clk) begin
        if (onOut === 1'b1) begin
            if (!prevOn) onStart = cyc;
            onLen++;
        end else if (prevOn) begin
            obsQ.push_back('{1'b1, onStart, onLen});
            onLen = 0;
        end
        if (offOut === 1'b1) begin
            if (!prevOff) offStart = cyc;
            offLen++;
        end else if (prevOff) begin
            obsQ.push_back('{1'b0, offStart, offLen});
            offLen = 0;
        end
        if (onOut === 1'b1 && offOut === 1'b1) overlapCount++;
        if ((onOut === 1'b1 && prevOff) || (offOut === 1'b1 && prevOn)) gapViolations++;
        prevOn = (onOut === 1'b1);
        prevOff = (offOut === 1'b1);
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold the main key high for highCycles cycles; sampleEdge is the first
    // edge that samples it high
    task automatic applyStimulus(input int highCycles, output int sampleEdge);
        key = 1'b1;
        sampleEdge = cyc + 1;
        repeat (highCycles) tick();
        key = 1'b0;
    endtask

    task automatic test_reset();
        pulse_t e, o;
        int r;
        rstN = 1'b0;
        repeat (3) tick();
        checks++;
        if (onOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_on: got %b, required 0", onOut); end
        checks++;
        if (offOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_off: got %b, required 0", offOut); end
        checks++;
        if (stateOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_state: got %b, required 0", stateOut); end
        rstN = 1'b1;
        r = cyc;
        expQ.push_back('{1'b0, r + 1, 2});
        repeat (8) tick();
        checks++;
        if (stateOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_state_after: got %b, required 0", stateOut); end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL reset_pulse: got none, required %s@%0d w%0d", e.isOn ? "ON" : "OFF", e.start, e.width);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL reset_pulse: got %s@%0d w%0d, required %s@%0d w%0d", o.isOn ? "ON" : "OFF", o.start, o.width, e.isOn ? "ON" : "OFF", e.start, e.width);
                end
            end
        end
        checks++;
        if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL reset_extra: got %0d extra pulses, required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_clean_press();
        pulse_t e, o;
        int s, s2, n;
        applyStimulus(6, s);
        expQ.push_back('{1'b1, s + DB + 3, 2});
        n = 0;
        while (stateOut !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (stateOut !== 1'b1 || cyc !== s + DB + 5) begin
            errors++;
            $display("[TB] FAIL press_hold_entry: got state %b at edge %0d, required 1 at edge %0d", stateOut, cyc, s + DB + 5);
        end
        while (cyc < s + 11) tick();
        applyStimulus(6, s2);
        checks++;
        if (stateOut !== 1'b1) begin errors++; $display("[TB] FAIL press_release_ignored: got state %b, required 1", stateOut); end
        expQ.push_back('{1'b0, s2 + DB + 3, 2});
        repeat (10) tick();
        checks++;
        if (stateOut !== 1'b0) begin errors++; $display("[TB] FAIL press_second_off: got state %b, required 0", stateOut); end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL press_pulse: got none, required %s@%0d w%0d", e.isOn ? "ON" : "OFF", e.start, e.width);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL press_pulse: got %s@%0d w%0d, required %s@%0d w%0d", o.isOn ? "ON" : "OFF", o.start, o.width, e.isOn ? "ON" : "OFF", e.start, e.width);
                end
            end
        end
        checks++;
        if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL press_extra: got %0d extra pulses, required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_bounce();
        pulse_t e, o;
        int s;
        repeat (10) tick();
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            tick();
        end
        key = 1'b1;
        s = cyc + 1;
        expQ.push_back('{1'b1, s + DB + 3, 2});
        expQ.push_back('{1'b0, s + DB + 5 + 16, 2});
        while (cyc < s + 10) tick();
        key = 1'b0;
        while (cyc < s + 32) tick();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL bounce_pulse: got none, required %s@%0d w%0d", e.isOn ? "ON" : "OFF", e.start, e.width);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL bounce_pulse: got %s@%0d w%0d, required %s@%0d w%0d", o.isOn ? "ON" : "OFF", o.start, o.width, e.isOn ? "ON" : "OFF", e.start, e.width);
                end
            end
        end
        checks++;
        if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL bounce_extra: got %0d extra pulses, required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_timeout();
        pulse_t e, o;
        int s, stateHigh;
        repeat (5) tick();
        applyStimulus(6, s);
        expQ.push_back('{1'b1, s + DB + 3, 2});
        expQ.push_back('{1'b0, s + DB + 5 + 16, 2});
        stateHigh = 0;
        repeat (40) begin
            tick();
            if (stateOut === 1'b1) stateHigh++;
        end
        checks++;
        if (stateHigh !== 16) begin errors++; $display("[TB] FAIL timeout_hold_cycles: got %0d, required 16", stateHigh); end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL timeout_pulse: got none, required %s@%0d w%0d", e.isOn ? "ON" : "OFF", e.start, e.width);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL timeout_pulse: got %s@%0d w%0d, required %s@%0d w%0d", o.isOn ? "ON" : "OFF", o.start, o.width, e.isOn ? "ON" : "OFF", e.start, e.width);
                end
            end
        end
        checks++;
        if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL timeout_extra: got %0d extra pulses, required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_timeout_disabled();
        int s, onCount, offCount, firstHold;
        key2 = 1'b1;
        s = cyc + 1;
        repeat (6) tick();
        key2 = 1'b0;
        onCount = 0;
        offCount = 0;
        firstHold = -1;
        repeat (60) begin
            tick();
            if (on2 === 1'b1) onCount++;
            if (off2 === 1'b1) offCount++;
            if (state2 === 1'b1 && firstHold < 0) firstHold = cyc;
        end
        checks++;
        if (onCount !== 2) begin errors++; $display("[TB] FAIL notimeout_on_width: got %0d, required 2", onCount); end
        checks++;
        if (firstHold !== s + DB + 5) begin errors++; $display("[TB] FAIL notimeout_hold_entry: got %0d, required %0d", firstHold, s + DB + 5); end
        checks++;
        if (offCount !== 0) begin errors++; $display("[TB] FAIL notimeout_off_cycles: got %0d, required 0", offCount); end
        checks++;
        if (state2 !== 1'b1) begin errors++; $display("[TB] FAIL notimeout_state: got %b, required 1", state2); end
    endtask

    task automatic test_force_off();
        pulse_t e, o;
        int s, s2, stateHigh;
        forceOff = 1'b1;
        repeat (3) tick();
        forceOff = 1'b0;
        repeat (3) tick();
        applyStimulus(6, s);
        expQ.push_back('{1'b1, s + DB + 3, 2});
        expQ.push_back('{1'b0, s + DB + 6, 2});
        while (cyc < s + DB + 3) tick();
        forceOff = 1'b1;
        tick();
        forceOff = 1'b0;
        stateHigh = 0;
        repeat (10) begin
            tick();
            if (stateOut === 1'b1) stateHigh++;
        end
        checks++;
        if (stateHigh !== 0) begin errors++; $display("[TB] FAIL force_kill_state: got %0d on cycles, required 0", stateHigh); end
        applyStimulus(6, s);
        expQ.push_back('{1'b1, s + DB + 3, 2});
        while (cyc < s + 11) tick();
        applyStimulus(6, s2);
        tick();
        forceOff = 1'b1;
        tick();
        forceOff = 1'b0;
        expQ.push_back('{1'b0, s2 + DB + 3, 2});
        repeat (12) tick();
        checks++;
        if (stateOut !== 1'b0) begin errors++; $display("[TB] FAIL force_hold_state: got %b, required 0", stateOut); end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL force_pulse: got none, required %s@%0d w%0d", e.isOn ? "ON" : "OFF", e.start, e.width);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL force_pulse: got %s@%0d w%0d, required %s@%0d w%0d", o.isOn ? "ON" : "OFF", o.start, o.width, e.isOn ? "ON" : "OFF", e.start, e.width);
                end
            end
        end
        checks++;
        if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL force_extra: got %0d extra pulses, required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_reset_mid_pulse();
        pulse_t e, o;
        int s, r;
        repeat (5) tick();
        applyStimulus(6, s);
        while (cyc < s + DB + 4) tick();
        expQ.push_back('{1'b1, s + DB + 3, 1});
        rstN = 1'b0;
        #1;
        checks++;
        if (onOut !== 1'b0) begin errors++; $display("[TB] FAIL midreset_on: got %b, required 0", onOut); end
        checks++;
        if (offOut !== 1'b0) begin errors++; $display("[TB] FAIL midreset_off: got %b, required 0", offOut); end
        tick();
        tick();
        rstN = 1'b1;
        r = cyc;
        expQ.push_back('{1'b0, r + 1, 2});
        repeat (8) tick();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL midreset_pulse: got none, required %s@%0d w%0d", e.isOn ? "ON" : "OFF", e.start, e.width);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL midreset_pulse: got %s@%0d w%0d, required %s@%0d w%0d", o.isOn ? "ON" : "OFF", o.start, o.width, e.isOn ? "ON" : "OFF", e.start, e.width);
                end
            end
        end
        checks++;
        if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL midreset_extra: got %0d extra pulses, required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlapCount !== 0) begin errors++; $display("[TB] FAIL exclusive_overlap: got %0d cycles, required 0", overlapCount); end
        checks++;
        if (gapViolations !== 0) begin errors++; $display("[TB] FAIL exclusive_gap: got %0d adjacencies, required 0", gapViolations); end
    endtask

    // Scenario sequence
    initial begin
        rstN = 1'b0;
        key = 1'b0;
        forceOff = 1'b0;
        key2 = 1'b0;
        force2 = 1'b0;
        $display("[TB] starting switch_driver checks");
        test_reset();
        test_clean_press();
        test_bounce();
        test_timeout();
        test_timeout_disabled();
        test_force_off();
        test_reset_mid_pulse();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
